e203_exu_wbck_arb: RTL

E203_EXU_WBCK_ARB -- requirements
Module: e203_exu_wbck_arb

---
 rtl/e203_exu_wbck_arb_pkg.sv | 20 ++
 rtl/e203_exu_wbck_arb_if.sv | 42 ++++
 rtl/e203_wbck_rr_arbiter.sv | 64 ++++++
 rtl/e203_exu_wbck_arb.sv | 89 ++++++++
 4 files changed

// File: rtl/e203_exu_wbck_arb_pkg.sv
// rtl/e203_exu_wbck_arb_pkg.sv - shared constants and helpers for the writeback arbiter
// Purpose: exception-flag width, default configuration and channel-index width helper.
package e203_exu_wbck_arb_pkg;

    localparam int FLAG_W      = 5;
    localparam int DEF_NCH     = 4;
    localparam int DEF_XLEN    = 32;
    localparam int DEF_RFIDX_W = 5;

    // Bits needed to index n channels (minimum 1 so a 2-channel build still has a pointer bit).
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/e203_exu_wbck_arb_if.sv
// rtl/e203_exu_wbck_arb_if.sv - writeback source channels and regfile write port bundle
// Purpose: groups the per-channel writeback requests, the regfile write port and the sticky flags.
// Signals:
//   wbck_i_valid/ready  per-channel handshake (NCH bits)
//   wbck_i_wdat         channel i data at [i*XLEN +: XLEN]
//   wbck_i_rdidx        channel i index at [i*RFIDX_W +: RFIDX_W]
//   wbck_i_flags        channel i exception flags at [i*FLAG_W +: FLAG_W]
//   rf_wbck_o_*         registered regfile write (valid/ready/wdat/rdidx)
//   fflags_o/fflags_clr sticky accumulated flags and their clear
// Modports: master = sources and regfile side, slave = arbiter.
interface e203_exu_wbck_arb_if
    import e203_exu_wbck_arb_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int XLEN    = DEF_XLEN,
    parameter int RFIDX_W = DEF_RFIDX_W
);
    logic [NCH-1:0]         wbck_i_valid;
    logic [NCH-1:0]         wbck_i_ready;
    logic [NCH*XLEN-1:0]    wbck_i_wdat;
    logic [NCH*RFIDX_W-1:0] wbck_i_rdidx;
    logic [NCH*FLAG_W-1:0]  wbck_i_flags;
    logic                   rf_wbck_o_valid;
    logic                   rf_wbck_o_ready;
    logic [XLEN-1:0]        rf_wbck_o_wdat;
    logic [RFIDX_W-1:0]     rf_wbck_o_rdidx;
    logic [FLAG_W-1:0]      fflags_o;
    logic                   fflags_clr;

    modport master (
        output wbck_i_valid, wbck_i_wdat, wbck_i_rdidx, wbck_i_flags,
        output rf_wbck_o_ready, fflags_clr,
        input  wbck_i_ready, rf_wbck_o_valid, rf_wbck_o_wdat, rf_wbck_o_rdidx, fflags_o
    );

    modport slave (
        input  wbck_i_valid, wbck_i_wdat, wbck_i_rdidx, wbck_i_flags,
        input  rf_wbck_o_ready, fflags_clr,
        output wbck_i_ready, rf_wbck_o_valid, rf_wbck_o_wdat, rf_wbck_o_rdidx, fflags_o
    );

endinterface

// File: rtl/e203_wbck_rr_arbiter.sv
// rtl/e203_wbck_rr_arbiter.sv - NCH-way one-hot grant for the writeback arbiter
// Purpose: picks at most one requester per cycle.
//   E203_WBCK_RR_EN defined  : round-robin from pointer, pointer advances past the winner on adv.
//   E203_WBCK_RR_EN undefined: fixed priority, highest index wins, no state.
// Ports: clk, rst_n, adv (handshake this cycle; RR build only), req[NCH], grant[NCH].
module e203_wbck_rr_arbiter
    import e203_exu_wbck_arb_pkg::*;
#(
    parameter int NCH = DEF_NCH
) (
`ifdef E203_WBCK_RR_EN
    input  logic           clk,
    input  logic           rst_n,
    input  logic           adv,
`endif
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] grant
);

`ifdef E203_WBCK_RR_EN
    localparam int IDX_W = clog2(NCH);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] gidx;
    logic             found;

    // Scan from ptr upward with wrap; the first requester seen wins.
    always_comb begin
        grant = '0;
        gidx  = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int off = 0; off < NCH; off++) begin
            cand = IDX_W'((int'(ptr) + off) % NCH);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                gidx        = cand;
            end
        end
    end

    // Pointer moves only on an actual transfer so a stalled winner keeps its turn.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (gidx == IDX_W'(NCH - 1)) ? '0 : gidx + IDX_W'(1);
        end
    end
`else
    always_comb begin
        grant = '0;
        for (int i = 0; i < NCH; i++) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// rtl/e203_exu_wbck_arb.sv - writeback arbiter: NCH sources into one registered regfile write port
// Purpose: grants one source per cycle into a single output register slot and accumulates
//          the accepted exception flags into a sticky fflags_o.
// Ports: clk, rst_n (synchronous, active-low), bus (e203_exu_wbck_arb_if.slave).
// Build option: E203_WBCK_RR_EN selects round-robin grant; default is fixed priority (high index wins).
module e203_exu_wbck_arb
    import e203_exu_wbck_arb_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int XLEN    = DEF_XLEN,
    parameter int RFIDX_W = DEF_RFIDX_W
) (
    input logic                clk,
    input logic                rst_n,
    e203_exu_wbck_arb_if.slave bus
);

    logic [NCH-1:0]     grant;
    logic               acc;
    logic               hs;
    logic               valid_q;
    logic [XLEN-1:0]    wdat_q;
    logic [RFIDX_W-1:0] rdidx_q;
    logic [FLAG_W-1:0]  fflags_q;
    logic [XLEN-1:0]    sel_wdat;
    logic [RFIDX_W-1:0] sel_rdidx;
    logic [FLAG_W-1:0]  sel_flags;

    e203_wbck_rr_arbiter #(.NCH(NCH)) u_arb (
`ifdef E203_WBCK_RR_EN
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (hs),
`endif
        .req   (bus.wbck_i_valid),
        .grant (grant)
    );

    // Slot can take new data when empty or being drained this cycle.
    assign acc = ~valid_q | bus.rf_wbck_o_ready;
    assign bus.wbck_i_ready = grant & {NCH{acc}};
    // grant is nonzero only when its channel is valid, so this is the handshake.
    assign hs = (|grant) & acc;

    always_comb begin
        sel_wdat  = '0;
        sel_rdidx = '0;
        sel_flags = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                sel_wdat  = bus.wbck_i_wdat[i*XLEN +: XLEN];
                sel_rdidx = bus.wbck_i_rdidx[i*RFIDX_W +: RFIDX_W];
                sel_flags = bus.wbck_i_flags[i*FLAG_W +: FLAG_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            wdat_q   <= '0;
            rdidx_q  <= '0;
            fflags_q <= '0;
        end else begin
            if (hs) begin
                valid_q <= 1'b1;
                wdat_q  <= sel_wdat;
                rdidx_q <= sel_rdidx;
            end else if (bus.rf_wbck_o_ready) begin
                valid_q <= 1'b0;
            end

            // Clear and accept together: the new flags survive the clear.
            if (hs && bus.fflags_clr) begin
                fflags_q <= sel_flags;
            end else if (hs) begin
                fflags_q <= fflags_q | sel_flags;
            end else if (bus.fflags_clr) begin
                fflags_q <= '0;
            end
        end
    end

    assign bus.rf_wbck_o_valid = valid_q;
    assign bus.rf_wbck_o_wdat  = wdat_q;
    assign bus.rf_wbck_o_rdidx = rdidx_q;
    assign bus.fflags_o        = fflags_q;

endmodule
